// File: rtl/defines.sv
// Shared opcode encoding for the 16/32-bit RISC pipeline.
package defines;

   typedef enum logic [5:0] {
      OP_NOP  = 6'd0,
      OP_ADD  = 6'd1,
      OP_SUB  = 6'd2,
      OP_AND  = 6'd3,
      OP_OR   = 6'd4,
      OP_NOR  = 6'd5,
      OP_XOR  = 6'd6,
      OP_SLA  = 6'd7,
      OP_SLL  = 6'd8,
      OP_SRA  = 6'd9,
      OP_SRL  = 6'd10,
      OP_ADDI = 6'd11,
      OP_SUBI = 6'd12,
      OP_LD   = 6'd13,
      OP_ST   = 6'd14,
      OP_BEZ  = 6'd15,
      OP_BNE  = 6'd16,
      OP_JMP  = 6'd17
   } opcode_t;

endpackage

// File: rtl/id_decode_stage_if.sv
// Fetch, write-back and ID/EX signal bundle of the decode stage.
interface id_decode_stage_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 16
);

   logic                     if_valid;
   logic [31:0]              if_instr;
   logic [PC_W-1:0]          if_pc;
   logic                     if_stall;
   logic                     flush;
   logic                     wb_en;
   logic [4:0]               wb_addr;
   logic signed [DATA_W-1:0] wb_data;
   logic                     id_valid;
   logic [5:0]               id_opcode;
   logic [4:0]               id_rd;
   logic signed [DATA_W-1:0] id_a;
   logic signed [DATA_W-1:0] id_b;
   logic signed [DATA_W-1:0] id_imm;
   logic [PC_W-1:0]          id_pc;
   logic                     id_reg_wr;
   logic                     id_mem_rd;
   logic                     id_mem_wr;
   logic                     id_branch;
   logic                     id_use_imm;
   logic                     id_illegal;

   modport master (
      output if_valid, if_instr, if_pc, flush, wb_en, wb_addr, wb_data,
      input  if_stall, id_valid, id_opcode, id_rd, id_a, id_b, id_imm, id_pc,
             id_reg_wr, id_mem_rd, id_mem_wr, id_branch, id_use_imm, id_illegal
   );

   modport slave (
      input  if_valid, if_instr, if_pc, flush, wb_en, wb_addr, wb_data,
      output if_stall, id_valid, id_opcode, id_rd, id_a, id_b, id_imm, id_pc,
             id_reg_wr, id_mem_rd, id_mem_wr, id_branch, id_use_imm, id_illegal
   );

endinterface

// File: rtl/id_decode_stage.sv
// Instruction decode: field split, register read with write-back bypass,
// load-use stall, flush, and the ID/EX pipeline register.
module id_decode_stage
   import defines::*;
#(
   parameter int DATA_W = 32,
   parameter int PC_W   = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   id_decode_stage_if.slave bus
);

   function automatic logic signed [DATA_W-1:0] sext_imm(input logic [15:0] v);
      return {{(DATA_W-16){v[15]}}, v};
   endfunction

   // R0 is hard-wired to zero, so it never takes the bypass either.
   function automatic logic signed [DATA_W-1:0] rd_bypass(
      input logic [4:0]               idx,
      input logic signed [DATA_W-1:0] stored,
      input logic                     we,
      input logic [4:0]               wa,
      input logic signed [DATA_W-1:0] wd
   );
      if (idx == 5'd0) return '0;
      if (we && (wa == idx)) return wd;
      return stored;
   endfunction

   logic signed [DATA_W-1:0] rf [32];

   logic [5:0]  op_raw;
   logic [4:0]  f_rd;
   logic [4:0]  f_rs1;
   logic [4:0]  f_rs2;
   logic [15:0] f_imm;

   opcode_t                  dec_op;
   logic                     dec_illegal;
   logic                     dec_fields;
   logic                     use_a;
   logic                     use_b;
   logic [4:0]               src_b;
   logic                     dec_reg_wr;
   logic                     dec_mem_rd;
   logic                     dec_mem_wr;
   logic                     dec_branch;
   logic                     dec_use_imm;
   logic signed [DATA_W-1:0] dec_a;
   logic signed [DATA_W-1:0] dec_b;
   logic signed [DATA_W-1:0] dec_imm;
   logic [4:0]               dec_rd;
   logic                     hazard;
   logic                     load_new;

   logic                     vld_p1;
   opcode_t                  op_p1;
   logic [4:0]               rd_p1;
   logic signed [DATA_W-1:0] a_p1;
   logic signed [DATA_W-1:0] b_p1;
   logic signed [DATA_W-1:0] imm_p1;
   logic [PC_W-1:0]          pc_p1;
   logic                     reg_wr_p1;
   logic                     mem_rd_p1;
   logic                     mem_wr_p1;
   logic                     branch_p1;
   logic                     use_imm_p1;
   logic                     illegal_p1;

   assign op_raw = bus.if_instr[31:26];
   assign f_rd   = bus.if_instr[25:21];
   assign f_rs1  = bus.if_instr[20:16];
   assign f_rs2  = bus.if_instr[15:11];
   assign f_imm  = bus.if_instr[15:0];

   always_comb begin
      dec_op      = OP_NOP;
      dec_illegal = 1'b0;
      dec_fields  = 1'b1;
      use_a       = 1'b0;
      use_b       = 1'b0;
      src_b       = f_rs2;
      dec_reg_wr  = 1'b0;
      dec_mem_rd  = 1'b0;
      dec_mem_wr  = 1'b0;
      dec_branch  = 1'b0;
      dec_use_imm = 1'b0;
      case (op_raw)
         OP_NOP: dec_fields = 1'b0;
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
         OP_XOR, OP_SLA, OP_SLL, OP_SRA, OP_SRL: begin
            use_a      = 1'b1;
            use_b      = 1'b1;
            dec_reg_wr = 1'b1;
         end
         OP_ADDI, OP_SUBI: begin
            use_a       = 1'b1;
            dec_use_imm = 1'b1;
            dec_reg_wr  = 1'b1;
         end
         OP_LD: begin
            use_a       = 1'b1;
            dec_use_imm = 1'b1;
            dec_mem_rd  = 1'b1;
            dec_reg_wr  = 1'b1;
         end
         // Stores and BNE take their second source from the rd field.
         OP_ST: begin
            use_a       = 1'b1;
            use_b       = 1'b1;
            src_b       = f_rd;
            dec_use_imm = 1'b1;
            dec_mem_wr  = 1'b1;
         end
         OP_BEZ: begin
            use_a      = 1'b1;
            dec_branch = 1'b1;
         end
         OP_BNE: begin
            use_a      = 1'b1;
            use_b      = 1'b1;
            src_b      = f_rd;
            dec_branch = 1'b1;
         end
         OP_JMP: dec_branch = 1'b1;
         default: begin
            dec_illegal = 1'b1;
            dec_fields  = 1'b0;
         end
      endcase
      if (!dec_illegal) dec_op = opcode_t'(op_raw);
   end

   assign dec_a   = use_a ? rd_bypass(f_rs1, rf[f_rs1], bus.wb_en, bus.wb_addr, bus.wb_data) : '0;
   assign dec_b   = use_b ? rd_bypass(src_b, rf[src_b], bus.wb_en, bus.wb_addr, bus.wb_data) : '0;
   assign dec_imm = dec_fields ? sext_imm(f_imm) : '0;
   assign dec_rd  = dec_fields ? f_rd : 5'd0;

   // A load in ID/EX whose result is needed now cannot be bypassed yet.
   assign hazard = bus.if_valid && vld_p1 && mem_rd_p1 && (rd_p1 != 5'd0) &&
                   ((use_a && (f_rs1 == rd_p1)) || (use_b && (src_b == rd_p1)));

   assign bus.if_stall = hazard && !bus.flush;
   assign load_new     = bus.if_valid && !bus.flush && !hazard;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
         rf[bus.wb_addr] <= bus.wb_data;
      end
   end

   // ---- ID/EX boundary (p1) ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         op_p1      <= OP_NOP;
         rd_p1      <= '0;
         a_p1       <= '0;
         b_p1       <= '0;
         imm_p1     <= '0;
         pc_p1      <= '0;
         reg_wr_p1  <= 1'b0;
         mem_rd_p1  <= 1'b0;
         mem_wr_p1  <= 1'b0;
         branch_p1  <= 1'b0;
         use_imm_p1 <= 1'b0;
         illegal_p1 <= 1'b0;
      end else if (load_new) begin
         vld_p1     <= 1'b1;
         op_p1      <= dec_op;
         rd_p1      <= dec_rd;
         a_p1       <= dec_a;
         b_p1       <= dec_b;
         imm_p1     <= dec_imm;
         pc_p1      <= bus.if_pc;
         reg_wr_p1  <= dec_reg_wr;
         mem_rd_p1  <= dec_mem_rd;
         mem_wr_p1  <= dec_mem_wr;
         branch_p1  <= dec_branch;
         use_imm_p1 <= dec_use_imm;
         illegal_p1 <= dec_illegal;
      end else begin
         vld_p1     <= 1'b0;
         op_p1      <= OP_NOP;
         rd_p1      <= '0;
         a_p1       <= '0;
         b_p1       <= '0;
         imm_p1     <= '0;
         pc_p1      <= '0;
         reg_wr_p1  <= 1'b0;
         mem_rd_p1  <= 1'b0;
         mem_wr_p1  <= 1'b0;
         branch_p1  <= 1'b0;
         use_imm_p1 <= 1'b0;
         illegal_p1 <= 1'b0;
      end
   end

   assign bus.id_valid   = vld_p1;
   assign bus.id_opcode  = op_p1;
   assign bus.id_rd      = rd_p1;
   assign bus.id_a       = a_p1;
   assign bus.id_b       = b_p1;
   assign bus.id_imm     = imm_p1;
   assign bus.id_pc      = pc_p1;
   assign bus.id_reg_wr  = reg_wr_p1;
   assign bus.id_mem_rd  = mem_rd_p1;
   assign bus.id_mem_wr  = mem_wr_p1;
   assign bus.id_branch  = branch_p1;
   assign bus.id_use_imm = use_imm_p1;
   assign bus.id_illegal = illegal_p1;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: expected ID/EX contents are queued
// when an instruction is driven and compared one edge later.
module tb_id_decode_stage;
   import defines::*;

   typedef struct packed {
      logic        valid;
      logic [5:0]  op;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [15:0] pc;
      logic [5:0]  flg;   // {reg_wr, mem_rd, mem_wr, branch, use_imm, illegal}
   } dec_t;

   typedef struct {
      logic        v;
      logic [31:0] ins;
      logic [15:0] pc;
      logic        fl;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        stall;
      dec_t        exp;
   } step_t;

   localparam logic [5:0] F_RW = 6'b100000;
   localparam logic [5:0] F_MR = 6'b010000;
   localparam logic [5:0] F_MW = 6'b001000;
   localparam logic [5:0] F_BR = 6'b000100;
   localparam logic [5:0] F_IM = 6'b000010;
   localparam logic [5:0] F_IL = 6'b000001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   dec_t sb[$];

   id_decode_stage_if #(.DATA_W(32), .PC_W(16)) bus ();

   id_decode_stage #(.DATA_W(32), .PC_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc(logic [5:0] op, logic [4:0] rd, logic [4:0] rs1, logic [15:0] lo);
      return {op, rd, rs1, lo};
   endfunction

   function automatic logic [31:0] rtype(logic [5:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
      return {op, rd, rs1, rs2, 11'd0};
   endfunction

   function automatic dec_t ex(logic v, logic [5:0] op, logic [4:0] rd, logic [31:0] a, logic [31:0] b,
                               logic [31:0] imm, logic [15:0] pc, logic [5:0] flg);
      dec_t d;
      d.valid = v; d.op = op; d.rd = rd; d.a = a; d.b = b; d.imm = imm; d.pc = pc; d.flg = flg;
      return d;
   endfunction

   function automatic dec_t bub();
      return ex(1'b0, OP_NOP, 5'd0, 32'd0, 32'd0, 32'd0, 16'd0, 6'd0);
   endfunction

   function automatic step_t sp(logic v, logic [31:0] ins, logic [15:0] pc, logic fl, logic we,
                                logic [4:0] wa, logic [31:0] wd, logic stall, dec_t e);
      step_t s;
      s.v = v; s.ins = ins; s.pc = pc; s.fl = fl; s.we = we; s.wa = wa; s.wd = wd; s.stall = stall; s.exp = e;
      return s;
   endfunction

   function automatic dec_t observe();
      dec_t o;
      o.valid = bus.id_valid;
      o.op    = bus.id_opcode;
      o.rd    = bus.id_rd;
      o.a     = bus.id_a;
      o.b     = bus.id_b;
      o.imm   = bus.id_imm;
      o.pc    = bus.id_pc;
      o.flg   = {bus.id_reg_wr, bus.id_mem_rd, bus.id_mem_wr, bus.id_branch, bus.id_use_imm, bus.id_illegal};
      return o;
   endfunction

   task automatic idle_inputs();
      bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.flush = 1'b0;
      bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
   endtask

   task automatic test_reset();
      dec_t got;
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      got = observe();
      n_chk++;
      if (got !== '0) begin n_err++; $display("FAIL reset_outputs: got %h exp 0", got); end
      n_chk++;
      if (bus.if_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b exp 0", bus.if_stall); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_rtype();
      step_t st[$];
      dec_t got, e;
      st.push_back(sp(0, 32'd0, 16'h0, 0, 1, 5'd1, 32'd5, 0, bub()));
      st.push_back(sp(0, 32'd0, 16'h0, 0, 1, 5'd2, 32'd3, 0, bub()));
      st.push_back(sp(1, rtype(OP_ADD, 3, 1, 2), 16'h0010, 0, 0, 0, 0, 0,
                      ex(1, OP_ADD, 3, 32'd5, 32'd3, 32'h1000, 16'h0010, F_RW)));
      st.push_back(sp(1, rtype(OP_XOR, 10, 2, 0), 16'h0012, 0, 0, 0, 0, 0,
                      ex(1, OP_XOR, 10, 32'd3, 32'd0, 32'h0, 16'h0012, F_RW)));
      foreach (st[i]) begin
         @(negedge clk);
         bus.if_valid = st[i].v; bus.if_instr = st[i].ins; bus.if_pc = st[i].pc; bus.flush = st[i].fl;
         bus.wb_en = st[i].we; bus.wb_addr = st[i].wa; bus.wb_data = st[i].wd;
         #1;
         n_chk++;
         if (bus.if_stall !== st[i].stall) begin n_err++; $display("FAIL rtype_stall[%0d]: got %b exp %b", i, bus.if_stall, st[i].stall); end
         sb.push_back(st[i].exp);
         @(posedge clk); #1;
         e = sb.pop_front(); got = observe(); n_chk++;
         if (e.valid ? (got !== e) : ({got.valid, got.op, got.flg} !== {e.valid, e.op, e.flg})) begin
            n_err++; $display("FAIL rtype_out[%0d]: got %h exp %h", i, got, e);
         end
      end
      idle_inputs();
   endtask

   task automatic test_imm_mem_branch();
      step_t st[$];
      dec_t got, e;
      st.push_back(sp(1, enc(OP_ADDI, 4, 1, 16'hFFFE), 16'h0014, 0, 0, 0, 0, 0,
                      ex(1, OP_ADDI, 4, 32'd5, 32'd0, 32'hFFFFFFFE, 16'h0014, F_IM | F_RW)));
      st.push_back(sp(1, enc(OP_ST, 2, 1, 16'h0008), 16'h0015, 0, 0, 0, 0, 0,
                      ex(1, OP_ST, 2, 32'd5, 32'd3, 32'h8, 16'h0015, F_IM | F_MW)));
      st.push_back(sp(1, enc(OP_BNE, 2, 1, 16'hFFF0), 16'h0016, 0, 0, 0, 0, 0,
                      ex(1, OP_BNE, 2, 32'd5, 32'd3, 32'hFFFFFFF0, 16'h0016, F_BR)));
      st.push_back(sp(1, enc(OP_BEZ, 2, 1, 16'h0004), 16'h0017, 0, 0, 0, 0, 0,
                      ex(1, OP_BEZ, 2, 32'd5, 32'd0, 32'h4, 16'h0017, F_BR)));
      st.push_back(sp(1, enc(OP_JMP, 0, 1, 16'h8000), 16'h0018, 0, 0, 0, 0, 0,
                      ex(1, OP_JMP, 0, 32'd0, 32'd0, 32'hFFFF8000, 16'h0018, F_BR)));
      foreach (st[i]) begin
         @(negedge clk);
         bus.if_valid = st[i].v; bus.if_instr = st[i].ins; bus.if_pc = st[i].pc; bus.flush = st[i].fl;
         bus.wb_en = st[i].we; bus.wb_addr = st[i].wa; bus.wb_data = st[i].wd;
         #1;
         n_chk++;
         if (bus.if_stall !== st[i].stall) begin n_err++; $display("FAIL imm_stall[%0d]: got %b exp %b", i, bus.if_stall, st[i].stall); end
         sb.push_back(st[i].exp);
         @(posedge clk); #1;
         e = sb.pop_front(); got = observe(); n_chk++;
         if (e.valid ? (got !== e) : ({got.valid, got.op, got.flg} !== {e.valid, e.op, e.flg})) begin
            n_err++; $display("FAIL imm_out[%0d]: got %h exp %h", i, got, e);
         end
      end
      idle_inputs();
   endtask

   task automatic test_load_use();
      step_t st[$];
      dec_t got, e;
      dec_t ld5;
      ld5 = ex(1, OP_LD, 5, 32'd5, 32'd0, 32'h4, 16'h0020, F_IM | F_MR | F_RW);
      st.push_back(sp(1, enc(OP_LD, 5, 1, 16'h0004), 16'h0020, 0, 0, 0, 0, 0, ld5));
      st.push_back(sp(1, rtype(OP_ADD, 6, 5, 2), 16'h0021, 0, 0, 0, 0, 1, bub()));
      st.push_back(sp(1, rtype(OP_ADD, 6, 5, 2), 16'h0021, 0, 1, 5'd5, 32'h77, 0,
                      ex(1, OP_ADD, 6, 32'h77, 32'd3, 32'h1000, 16'h0021, F_RW)));
      st.push_back(sp(1, enc(OP_LD, 0, 1, 16'h0000), 16'h0022, 0, 0, 0, 0, 0,
                      ex(1, OP_LD, 0, 32'd5, 32'd0, 32'h0, 16'h0022, F_IM | F_MR | F_RW)));
      st.push_back(sp(1, rtype(OP_ADD, 7, 0, 0), 16'h0023, 0, 0, 0, 0, 0,
                      ex(1, OP_ADD, 7, 32'd0, 32'd0, 32'h0, 16'h0023, F_RW)));
      st.push_back(sp(1, enc(OP_LD, 5, 1, 16'h0000), 16'h0024, 0, 0, 0, 0, 0,
                      ex(1, OP_LD, 5, 32'd5, 32'd0, 32'h0, 16'h0024, F_IM | F_MR | F_RW)));
      st.push_back(sp(1, enc(OP_ST, 5, 2, 16'h0000), 16'h0025, 0, 0, 0, 0, 1, bub()));
      st.push_back(sp(1, enc(OP_ST, 5, 2, 16'h0000), 16'h0025, 0, 0, 0, 0, 0,
                      ex(1, OP_ST, 5, 32'd3, 32'h77, 32'h0, 16'h0025, F_IM | F_MW)));
      st.push_back(sp(1, enc(OP_LD, 5, 1, 16'h0000), 16'h0026, 0, 0, 0, 0, 0,
                      ex(1, OP_LD, 5, 32'd5, 32'd0, 32'h0, 16'h0026, F_IM | F_MR | F_RW)));
      st.push_back(sp(1, enc(OP_ADDI, 8, 2, 16'h2800), 16'h0027, 0, 0, 0, 0, 0,
                      ex(1, OP_ADDI, 8, 32'd3, 32'd0, 32'h2800, 16'h0027, F_IM | F_RW)));
      foreach (st[i]) begin
         @(negedge clk);
         bus.if_valid = st[i].v; bus.if_instr = st[i].ins; bus.if_pc = st[i].pc; bus.flush = st[i].fl;
         bus.wb_en = st[i].we; bus.wb_addr = st[i].wa; bus.wb_data = st[i].wd;
         #1;
         n_chk++;
         if (bus.if_stall !== st[i].stall) begin n_err++; $display("FAIL loaduse_stall[%0d]: got %b exp %b", i, bus.if_stall, st[i].stall); end
         sb.push_back(st[i].exp);
         @(posedge clk); #1;
         e = sb.pop_front(); got = observe(); n_chk++;
         if (e.valid ? (got !== e) : ({got.valid, got.op, got.flg} !== {e.valid, e.op, e.flg})) begin
            n_err++; $display("FAIL loaduse_out[%0d]: got %h exp %h", i, got, e);
         end
      end
      idle_inputs();
   endtask

   task automatic test_bypass();
      step_t st[$];
      dec_t got, e;
      st.push_back(sp(1, rtype(OP_SUB, 8, 7, 2), 16'h0030, 0, 1, 5'd7, 32'hDEAD, 0,
                      ex(1, OP_SUB, 8, 32'hDEAD, 32'd3, 32'h1000, 16'h0030, F_RW)));
      st.push_back(sp(1, rtype(OP_SUB, 8, 0, 2), 16'h0031, 0, 1, 5'd0, 32'hDEAD, 0,
                      ex(1, OP_SUB, 8, 32'd0, 32'd3, 32'h1000, 16'h0031, F_RW)));
      st.push_back(sp(1, rtype(OP_SUB, 9, 7, 7), 16'h0032, 0, 0, 0, 0, 0,
                      ex(1, OP_SUB, 9, 32'hDEAD, 32'hDEAD, 32'h3800, 16'h0032, F_RW)));
      st.push_back(sp(1, rtype(OP_SUB, 9, 7, 7), 16'h0033, 0, 1, 5'd7, 32'h1234, 0,
                      ex(1, OP_SUB, 9, 32'h1234, 32'h1234, 32'h3800, 16'h0033, F_RW)));
      st.push_back(sp(1, rtype(OP_SUB, 9, 0, 7), 16'h0034, 0, 0, 0, 0, 0,
                      ex(1, OP_SUB, 9, 32'd0, 32'h1234, 32'h3800, 16'h0034, F_RW)));
      foreach (st[i]) begin
         @(negedge clk);
         bus.if_valid = st[i].v; bus.if_instr = st[i].ins; bus.if_pc = st[i].pc; bus.flush = st[i].fl;
         bus.wb_en = st[i].we; bus.wb_addr = st[i].wa; bus.wb_data = st[i].wd;
         #1;
         n_chk++;
         if (bus.if_stall !== st[i].stall) begin n_err++; $display("FAIL bypass_stall[%0d]: got %b exp %b", i, bus.if_stall, st[i].stall); end
         sb.push_back(st[i].exp);
         @(posedge clk); #1;
         e = sb.pop_front(); got = observe(); n_chk++;
         if (e.valid ? (got !== e) : ({got.valid, got.op, got.flg} !== {e.valid, e.op, e.flg})) begin
            n_err++; $display("FAIL bypass_out[%0d]: got %h exp %h", i, got, e);
         end
      end
      idle_inputs();
   endtask

   task automatic test_flush_illegal();
      step_t st[$];
      dec_t got, e;
      st.push_back(sp(1, enc(OP_LD, 5, 1, 16'h0000), 16'h0040, 0, 0, 0, 0, 0,
                      ex(1, OP_LD, 5, 32'd5, 32'd0, 32'h0, 16'h0040, F_IM | F_MR | F_RW)));
      st.push_back(sp(1, rtype(OP_ADD, 6, 5, 2), 16'h0041, 1, 0, 0, 0, 0, bub()));
      st.push_back(sp(1, rtype(OP_ADD, 6, 5, 2), 16'h0041, 0, 0, 0, 0, 0,
                      ex(1, OP_ADD, 6, 32'h77, 32'd3, 32'h1000, 16'h0041, F_RW)));
      st.push_back(sp(1, enc(6'h3F, 9, 1, 16'h1234), 16'h0042, 0, 0, 0, 0, 0,
                      ex(1, OP_NOP, 0, 32'd0, 32'd0, 32'h0, 16'h0042, F_IL)));
      st.push_back(sp(1, 32'd0, 16'h0043, 0, 0, 0, 0, 0,
                      ex(1, OP_NOP, 0, 32'd0, 32'd0, 32'h0, 16'h0043, 6'd0)));
      st.push_back(sp(0, rtype(OP_ADD, 1, 1, 1), 16'h0044, 0, 0, 0, 0, 0, bub()));
      foreach (st[i]) begin
         @(negedge clk);
         bus.if_valid = st[i].v; bus.if_instr = st[i].ins; bus.if_pc = st[i].pc; bus.flush = st[i].fl;
         bus.wb_en = st[i].we; bus.wb_addr = st[i].wa; bus.wb_data = st[i].wd;
         #1;
         n_chk++;
         if (bus.if_stall !== st[i].stall) begin n_err++; $display("FAIL flush_stall[%0d]: got %b exp %b", i, bus.if_stall, st[i].stall); end
         sb.push_back(st[i].exp);
         @(posedge clk); #1;
         e = sb.pop_front(); got = observe(); n_chk++;
         if (e.valid ? (got !== e) : ({got.valid, got.op, got.flg} !== {e.valid, e.op, e.flg})) begin
            n_err++; $display("FAIL flush_out[%0d]: got %h exp %h", i, got, e);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_stall();
      dec_t got, e;
      @(negedge clk);
      bus.if_valid = 1'b1; bus.if_instr = enc(OP_LD, 5, 1, 16'h0000); bus.if_pc = 16'h0050;
      sb.push_back(ex(1, OP_LD, 5, 32'd5, 32'd0, 32'h0, 16'h0050, F_IM | F_MR | F_RW));
      @(posedge clk); #1;
      e = sb.pop_front(); got = observe(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL rstmid_ld: got %h exp %h", got, e); end
      @(negedge clk);
      bus.if_instr = rtype(OP_ADD, 6, 5, 2); bus.if_pc = 16'h0051;
      #1;
      n_chk++;
      if (bus.if_stall !== 1'b1) begin n_err++; $display("FAIL rstmid_stall_before: got %b exp 1", bus.if_stall); end
      #1;
      rst_n = 1'b0;
      #1;
      got = observe(); n_chk++;
      if (got !== '0) begin n_err++; $display("FAIL rstmid_outputs: got %h exp 0", got); end
      n_chk++;
      if (bus.if_stall !== 1'b0) begin n_err++; $display("FAIL rstmid_stall_after: got %b exp 0", bus.if_stall); end
      @(negedge clk);
      rst_n = 1'b1;
      bus.if_instr = rtype(OP_ADD, 3, 1, 2); bus.if_pc = 16'h0060;
      sb.push_back(ex(1, OP_ADD, 3, 32'd0, 32'd0, 32'h1000, 16'h0060, F_RW));
      @(posedge clk); #1;
      e = sb.pop_front(); got = observe(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL rstmid_rf_cleared: got %h exp %h", got, e); end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_imm_mem_branch();
      test_load_use();
      test_bypass();
      test_flush_illegal();
      test_reset_mid_stall();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
